// File: rtl/reg_access_sequencer_if.sv
// Instruction handshake, register-file access bus and status outputs of the sequencer.
// The master modport is the sequencer side; slave is the environment / register file side.
interface reg_access_sequencer_if #(
  parameter int WORD_SIZE = 8,
  parameter int REG_BITS  = 3
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [2:0]           opcode;
  logic [REG_BITS-1:0]  rd;
  logic [REG_BITS-1:0]  rs1;
  logic [REG_BITS-1:0]  rs2;
  logic [WORD_SIZE-1:0] imm;

  logic [REG_BITS-1:0]  rf_num1;
  logic [REG_BITS-1:0]  rf_num2;
  logic                 rf_get_enable;
  logic                 rf_set_enable;
  logic [REG_BITS-1:0]  rf_set_num;
  logic [WORD_SIZE-1:0] rf_set_val;
  logic                 rf_reset_enable;
  logic [WORD_SIZE-1:0] rf_out1;
  logic [WORD_SIZE-1:0] rf_out2;

  logic [WORD_SIZE-1:0] result;
  logic                 carry;
  logic                 zero;
  logic                 done;

  modport master (
    input  instr_valid, opcode, rd, rs1, rs2, imm, rf_out1, rf_out2,
    output instr_ready, rf_num1, rf_num2, rf_get_enable, rf_set_enable,
           rf_set_num, rf_set_val, rf_reset_enable, result, carry, zero, done
  );

  modport slave (
    output instr_valid, opcode, rd, rs1, rs2, imm, rf_out1, rf_out2,
    input  instr_ready, rf_num1, rf_num2, rf_get_enable, rf_set_enable,
           rf_set_num, rf_set_val, rf_reset_enable, result, carry, zero, done
  );
endinterface

// File: rtl/reg_access_sequencer.sv
// Issue/execute sequencer in front of an 8-entry register file: reads operands,
// runs one ALU op, then writes back or clears the file, one instruction at a time.
module reg_access_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int REG_BITS  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  reg_access_sequencer_if.master bus
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, CLEAR, FINISH} state_t;

  state_t               state, state_nxt;
  logic [2:0]           op_p0;
  logic [REG_BITS-1:0]  rd_p0, rs1_p0, rs2_p0;
  logic [WORD_SIZE-1:0] result_q;
  logic                 carry_q, zero_q;
  logic [WORD_SIZE:0]   alu_out;
  logic                 accept;

  logic                 ready_c, get_c, set_c, clr_c, done_c;
  logic [REG_BITS-1:0]  num1_c, num2_c, set_num_c;
  logic [WORD_SIZE-1:0] set_val_c;

  // Returns {carry, result}; logic ops pass the incoming carry through unchanged.
  function automatic logic [WORD_SIZE:0] alu(input logic [2:0] op,
                                             input logic [WORD_SIZE-1:0] a,
                                             input logic [WORD_SIZE-1:0] b,
                                             input logic c_in);
    logic [WORD_SIZE:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};   // MSB set exactly when a < b (borrow)
      OP_AND:  r = {c_in, a & b};
      OP_OR:   r = {c_in, a | b};
      OP_XOR:  r = {c_in, a ^ b};
      default: r = {c_in, a};
    endcase
    return r;
  endfunction

  assign accept  = bus.instr_valid && (state == IDLE);
  assign alu_out = alu(op_p0, bus.rf_out1, bus.rf_out2, carry_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Accept edge latches the instruction; LDI and CLR settle the status here,
  // ALU ops settle it on the edge leaving EXEC while read data is valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_p0    <= '0;
      rd_p0    <= '0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_p0  <= bus.opcode;
        rd_p0  <= bus.rd;
        rs1_p0 <= bus.rs1;
        rs2_p0 <= bus.rs2;
        if (bus.opcode == OP_LDI) begin
          result_q <= bus.imm;
          zero_q   <= (bus.imm == '0);
        end else if (bus.opcode == OP_CLR) begin
          result_q <= '0;
          carry_q  <= 1'b0;
          zero_q   <= 1'b0;
        end
      end
      if (state == EXEC) begin
        result_q <= alu_out[WORD_SIZE-1:0];
        carry_q  <= alu_out[WORD_SIZE];
        zero_q   <= (alu_out[WORD_SIZE-1:0] == '0);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    get_c     = 1'b0;
    set_c     = 1'b0;
    clr_c     = 1'b0;
    done_c    = 1'b0;
    num1_c    = '0;
    num2_c    = '0;
    set_num_c = '0;
    set_val_c = '0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          case (bus.opcode)
            OP_NOP:  state_nxt = FINISH;
            OP_LDI:  state_nxt = WRITE;
            OP_CLR:  state_nxt = CLEAR;
            default: state_nxt = READ;
          endcase
        end
      end
      READ: begin
        get_c     = 1'b1;
        num1_c    = rs1_p0;
        num2_c    = rs2_p0;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = WRITE;
      WRITE: begin
        set_c     = 1'b1;
        set_num_c = rd_p0;
        set_val_c = result_q;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      CLEAR: begin
        clr_c     = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      FINISH: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.instr_ready     = ready_c;
  assign bus.rf_get_enable   = get_c;
  assign bus.rf_num1         = num1_c;
  assign bus.rf_num2         = num2_c;
  assign bus.rf_set_enable   = set_c;
  assign bus.rf_set_num      = set_num_c;
  assign bus.rf_set_val      = set_val_c;
  assign bus.rf_reset_enable = clr_c;
  assign bus.done            = done_c;
  assign bus.result          = result_q;
  assign bus.carry           = carry_q;
  assign bus.zero            = zero_q;

endmodule
